// File: rtl/multdiv_pkg.sv
// Shared constants and FSM state type for the multdiv path.
// Define MULT_RADIX4_EN to select radix-4 modified Booth (16 steps) instead of radix-2 (32 steps).
package multdiv_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 6;

`ifdef MULT_RADIX4_EN
  // Two multiplier bits retired per step; +-2A needs one more accumulator bit.
  localparam int RADIX_SHIFT = 2;
  localparam int ACC_EXT     = 2;
  localparam int ITER_COUNT  = 16;
`else
  localparam int RADIX_SHIFT = 1;
  localparam int ACC_EXT     = 1;
  localparam int ITER_COUNT  = 32;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract the multiplicand into the accumulator, then arithmetic shift.
// Recoding follows MULT_RADIX4_EN (radix-4 on P[2:0]) or radix-2 on P[1:0] when undefined.
module booth_step #(
  parameter int DATA_W  = multdiv_pkg::DATA_W,
  parameter int ACC_W   = DATA_W + multdiv_pkg::ACC_EXT,
  parameter int BOOTH_W = multdiv_pkg::RADIX_SHIFT + 1
) (
  input  logic [ACC_W-1:0]        acc,
  input  logic [ACC_W-1:0]        mcand,
  input  logic [BOOTH_W-1:0]      booth,
  input  logic [DATA_W:0]         low,
  output logic [ACC_W+DATA_W:0]   p_next
);
  import multdiv_pkg::*;

  localparam int P_W = ACC_W + DATA_W + 1;

  logic [ACC_W-1:0]      sum;
  logic signed [P_W-1:0] p_sum;

  always_comb begin
    sum = acc;
`ifdef MULT_RADIX4_EN
    unique case (booth)
      3'b001, 3'b010: sum = acc + mcand;
      3'b011:         sum = acc + (mcand << 1);
      3'b100:         sum = acc - (mcand << 1);
      3'b101, 3'b110: sum = acc - mcand;
      default:        sum = acc;
    endcase
`else
    unique case (booth)
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
`endif
    p_sum  = {sum, low};
    p_next = p_sum >>> RADIX_SHIFT;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed Booth multiplier: start pulse in, 64-bit product with one-cycle result_valid out.
// MULT_RADIX4_EN halves the latency (16 steps) with radix-4 recoding; default is radix-2, 32 steps.
module booth_mult_seq #(
  parameter int DATA_W = multdiv_pkg::DATA_W,
  parameter int CNT_W  = multdiv_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  busy,
  output logic                  result_valid,
  output logic [2*DATA_W-1:0]   product,
  output logic                  overflow
);
  import multdiv_pkg::*;

  localparam int ACC_W   = DATA_W + ACC_EXT;
  localparam int P_W     = ACC_W + DATA_W + 1;
  localparam int BOOTH_W = RADIX_SHIFT + 1;
  localparam int STEPS   = DATA_W / RADIX_SHIFT;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   a_reg;
  logic [P_W-1:0]     p;
  logic [P_W-1:0]     p_next;
  logic [2*DATA_W-1:0] final_prod;
  logic               final_ovf;

  booth_step #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .BOOTH_W (BOOTH_W)
  ) u_step (
    .acc    (p[P_W-1 -: ACC_W]),
    .mcand  (a_reg),
    .booth  (p[BOOTH_W-1:0]),
    .low    (p[DATA_W:0]),
    .p_next (p_next)
  );

  // Product sits just above the guard bit once all multiplier bits are shifted out.
  assign final_prod = p_next[2*DATA_W:1];
  assign final_ovf  = final_prod[2*DATA_W-1:DATA_W] != {DATA_W{final_prod[DATA_W-1]}};

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      a_reg        <= '0;
      p            <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      product      <= '0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= {{ACC_EXT{multiplicand[DATA_W-1]}}, multiplicand};
            p     <= {{ACC_W{1'b0}}, multiplier, 1'b0};
            cnt   <= '0;
            state <= BUSY;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            product      <= final_prod;
            overflow     <= final_ovf;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised and directed bench for booth_mult_seq against a plain signed-arithmetic reference.
// Expected latency follows MULT_RADIX4_EN (16) or the default radix-2 build (32).
module tb_booth_mult_seq;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        result_valid;
  logic [63:0] product;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  booth_mult_seq dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .result_valid (result_valid),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
    longint sp;
    sp = longint'($signed(a)) * longint'($signed(b));
    return (sp < -(longint'(1) <<< 31)) || (sp > ((longint'(1) <<< 31) - 1));
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic collect(output int lat, output int busy_cycles, output int valid_cycles,
                         output int both_high, output logic [63:0] prod, output logic ovf);
    lat = -1; busy_cycles = 0; valid_cycles = 0; both_high = 0;
    prod = '0; ovf = 1'b0;
    for (int j = 0; j <= LAT + 4; j++) begin
      if (busy) busy_cycles++;
      if (busy && result_valid) both_high++;
      if (result_valid) begin
        valid_cycles++;
        if (lat < 0) begin
          lat  = j;
          prod = product;
          ovf  = overflow;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat, bc, vc, bh;
    logic [63:0] prod;
    logic ovf;
    logic [63:0] exp_p;
    exp_p = ref_mul(a, b);
    launch(a, b);
    collect(lat, bc, vc, bh, prod, ovf);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT); end
    vectors++;
    if (prod !== exp_p) begin miscompares++; $display("FAIL %s product: got %h expected %h", name, prod, exp_p); end
    vectors++;
    if (ovf !== ref_ovf(a, b)) begin miscompares++; $display("FAIL %s overflow: got %b expected %b", name, ovf, ref_ovf(a, b)); end
    vectors++;
    if (bc !== LAT) begin miscompares++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, LAT); end
    vectors++;
    if (vc !== 1) begin miscompares++; $display("FAIL %s valid_cycles: got %0d expected 1", name, vc); end
    vectors++;
    if (bh !== 0) begin miscompares++; $display("FAIL %s busy_and_valid: got %0d expected 0", name, bh); end
    vectors++;
    if (product !== exp_p) begin miscompares++; $display("FAIL %s product_held: got %h expected %h", name, product, exp_p); end
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset result_valid: got %b expected 0", result_valid); end
    vectors++;
    if (product !== 64'd0) begin miscompares++; $display("FAIL reset product: got %h expected 0", product); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset overflow: got %b expected 0", overflow); end
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [7] = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] vb [7] = '{32'd5, 32'h0000_0006, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [63:0] p;
    for (int i = 0; i < 7; i++) check_op($sformatf("directed%0d", i), va[i], vb[i]);
    // anchor the reference model against hand-computed values
    p = ref_mul(32'd3, 32'd5);
    vectors++;
    if (p !== 64'h0000_0000_0000_000F) begin miscompares++; $display("FAIL model_3x5: got %h expected f", p); end
    p = ref_mul(32'h8000_0000, 32'h8000_0000);
    vectors++;
    if (p !== 64'h4000_0000_0000_0000) begin miscompares++; $display("FAIL model_min_sq: got %h expected 4000000000000000", p); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = {{20{a[31]}}, a[11:0]};
      if (i % 4 == 2) b = {{20{b[31]}}, b[11:0]};
      check_op($sformatf("random%0d", i), a, b);
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1, vc = 0, bc = 0;
    launch(32'd12, 32'd12);
    for (int j = 0; j <= LAT + 4; j++) begin
      if (busy) bc++;
      if (result_valid) begin
        vc++;
        if (lat < 0) lat = j;
      end
      if (j == 10) begin
        multiplicand = 32'd2; multiplier = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL ignore_start latency: got %0d expected %0d", lat, LAT); end
    vectors++;
    if (vc !== 1) begin miscompares++; $display("FAIL ignore_start valid_cycles: got %0d expected 1", vc); end
    vectors++;
    if (bc !== LAT) begin miscompares++; $display("FAIL ignore_start busy_cycles: got %0d expected %0d", bc, LAT); end
    vectors++;
    if (product !== 64'd144) begin miscompares++; $display("FAIL ignore_start product: got %h expected 90", product); end
  endtask

  task automatic test_clear_mid();
    int vc = 0;
    launch(32'd9, 32'd9);
    repeat (15) @(negedge clk);
    clear = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_mid busy: got %b expected 0", busy); end
    vectors++;
    if (product !== 64'd0) begin miscompares++; $display("FAIL clear_mid product: got %h expected 0", product); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL clear_mid overflow: got %b expected 0", overflow); end
    @(negedge clk);
    clear = 1'b0;
    for (int j = 0; j <= LAT + 4; j++) begin
      if (result_valid || busy) vc++;
      @(negedge clk);
    end
    vectors++;
    if (vc !== 0) begin miscompares++; $display("FAIL clear_mid activity_after_clear: got %0d expected 0", vc); end
    check_op("after_clear", 32'd4, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    int lat, bc, vc, bh, j;
    logic [63:0] prod;
    logic ovf;
    logic found = 1'b0;
    launch(32'd2, 32'd3);
    for (j = 0; j <= LAT + 4; j++) begin
      if (result_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!found || j !== LAT) begin miscompares++; $display("FAIL b2b first_latency: got %0d expected %0d", j, LAT); end
    vectors++;
    if (product !== 64'd6) begin miscompares++; $display("FAIL b2b first_product: got %h expected 6", product); end
    launch(32'd5, 32'd5);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b busy_after_accept: got %b expected 1", busy); end
    vectors++;
    if (product !== 64'd6) begin miscompares++; $display("FAIL b2b product_kept: got %h expected 6", product); end
    collect(lat, bc, vc, bh, prod, ovf);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL b2b second_latency: got %0d expected %0d", lat, LAT); end
    vectors++;
    if (prod !== 64'd25) begin miscompares++; $display("FAIL b2b second_product: got %h expected 19", prod); end
    vectors++;
    if (vc !== 1) begin miscompares++; $display("FAIL b2b second_valid_cycles: got %0d expected 1", vc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_clear_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Iterative signed 32x32 Booth multiplier for the processor's multdiv path.
- Directly upstream of the 64-bit product register: its `product` output feeds that register's data input.
- Accepts operands on a one-cycle `start` pulse, iterates internally, then presents a 64-bit two's-complement product with a one-cycle `result_valid` strobe and an overflow flag for 32-bit writeback.

Parameters:
- DATA_W, 32, operand width in bits; product width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- start  input  1  operand-capture strobe; honoured only in IDLE or DONE.
- multiplicand  input  DATA_W  signed operand A.
- multiplier  input  DATA_W  signed operand B.
- busy  output  1  high while iterating.
- result_valid  output  1  one-cycle strobe; product/overflow valid.
- product  output  2*DATA_W  signed A*B; held until next accepted start.
- overflow  output  1  product[63:32] is not the sign extension of product[31].

Behaviour:
- Interface: one clock, `clk`; reset `clear` is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state = IDLE; busy = 0, result_valid = 0, product = 0, overflow = 0.
  - Counter and internal A/P registers = 0; in-flight operation discarded, no result produced.
- States:
  - IDLE: wait for start.
  - BUSY: one Booth step per clock.
  - DONE: result_valid = 1 for exactly one cycle, then return to IDLE.
- Accept: on the edge where start = 1 in IDLE or DONE:
  - Latch A = multiplicand, sign-extended to 33 bits.
  - Load P = {33'b0, multiplier, 1'b0} (66 bits: upper 33 accumulator, multiplier, Booth guard bit).
  - Counter = 0; go to BUSY.
- BUSY step on each edge, using P[1:0]:
  - 01: upper33 += A.
  - 10: upper33 -= A.
  - 00 / 11: no change.
  - Then arithmetic shift right of P by 1; counter += 1.
  - The 33-bit accumulator guarantees multiplicand = -2^31 is handled without wrap.
- After the 32nd step go to DONE; product = P[64:1]; overflow computed from that value.
  - result_valid rises exactly 32 clocks after the accept edge.
- start during BUSY is ignored: no restart, no operand relatch.
- start in DONE: the current result is still strobed that cycle; the new operation is accepted on the same edge (back-to-back with no bubble).
- busy = 1 exactly in BUSY; busy and result_valid are never both high.
- product and overflow are registered outputs, stable from DONE until the next accept edge.
  - At the accept edge product is not cleared; it updates only at the next DONE.
- Operand inputs are sampled only at the accept edge; changes afterwards have no effect.

Optional Feature:
- MULT_RADIX4_EN defined:
  - Radix-4 modified Booth; each step examines P[2:0] and adds 0, ±A or ±2A.
  - Accumulator widened to 34 bits; arithmetic shift by 2 per step.
  - 16 steps; result_valid 16 clocks after accept.
- Undefined: radix-2 as above, 32 steps.
- Ports, reset and handshake rules are identical in both builds; only latency differs.

Decomposition:
- Shared package `multdiv_pkg`:
  - constants DATA_W, PROD_W = 64, CNT_W, ITER_COUNT (32, or 16 under MULT_RADIX4_EN);
  - state enum {IDLE, BUSY, DONE} with 2-bit encoding.
- Sub-module `booth_step`: purely combinational.
  - Inputs: accumulator, multiplicand, Booth bits.
  - Output: next P after add/sub and arithmetic shift.
  - Instantiated once; the sequencing FSM, counter and output registers stay in booth_mult_seq.

Test Plan:
- Reset then 3 * 5 -> after 32 clocks result_valid = 1 for one cycle; product = 64'h0000_0000_0000_000F, overflow = 0; busy high for exactly 32 cycles.
- -7 * 6 (32'hFFFF_FFF9, 32'h0000_0006) -> product = 64'hFFFF_FFFF_FFFF_FFD6, overflow = 0.
- 32'h8000_0000 * 32'h8000_0000 -> product = 64'h4000_0000_0000_0000, overflow = 1; also 32'h0001_0000 * 32'h0001_0000 -> 64'h0000_0001_0000_0000, overflow = 1.
- Start 12 * 12; pulse start with 2 * 2 at cycle 10 -> ignored; product = 64'd144 at cycle 32; no second result_valid.
- Start 9 * 9; assert clear at cycle 15 for one cycle -> busy, product, overflow immediately 0; no result_valid; next op 4 * -1 gives 64'hFFFF_FFFF_FFFF_FFFC.
- Start asserted in the DONE cycle of 2 * 3 with new operands 5 * 5 -> result_valid shows 6; busy rises next cycle; second result 25 arrives exactly 32 clocks later (16 under MULT_RADIX4_EN, where all cases above must also pass).
